// File: rtl/fwpic_reg_arb.sv
// Round-robin arbiter that lets N_INIT register-bus initiators share the single fwpic
// register port, with per-grant timeout and request-withdrawal handling.
module fwpic_reg_arb #(
    parameter int unsigned N_INIT    = 2,
    parameter int unsigned ADR_WIDTH = 4,
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_INIT*ADR_WIDTH-1:0]   i_adr,
    input  logic [N_INIT*DAT_WIDTH-1:0]   i_dat_w,
    input  logic [N_INIT-1:0]             i_we,
    input  logic [N_INIT-1:0]             i_valid,
    output logic [N_INIT-1:0]             i_ready,
    output logic [DAT_WIDTH-1:0]          i_dat_r,
    output logic [ADR_WIDTH-1:0]          t_adr,
    output logic [DAT_WIDTH-1:0]          t_dat_w,
    output logic                          t_we,
    output logic                          t_valid,
    input  logic                          t_ready,
    input  logic [DAT_WIDTH-1:0]          t_dat_r,
    output logic [2:0]                    gnt_idx,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned MAX_INIT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_adv;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     hi_idx;
    logic [IDX_W-1:0]     lo_idx;
    logic                 hi_found;
    logic                 pick_any;
    logic [CNT_W-1:0]     cnt;
    logic                 gnt_vld;
    logic                 timeout;
    logic                 done;
    logic [MAX_INIT-1:0]  vld8;
    logic [MAX_INIT-1:0]  we8;
    logic [MAX_INIT-1:0]  rdy8;
    logic [ADR_WIDTH-1:0] adr_a [MAX_INIT];
    logic [DAT_WIDTH-1:0] dat_a [MAX_INIT];

    // Unpack per-initiator slices into fixed 8-entry tables indexed by the 3-bit grant
    for (genvar g = 0; g < int'(MAX_INIT); g++) begin : g_unpack
        if (g < int'(N_INIT)) begin : g_live
            assign vld8[g]  = i_valid[g];
            assign we8[g]   = i_we[g];
            assign adr_a[g] = i_adr[g*ADR_WIDTH +: ADR_WIDTH];
            assign dat_a[g] = i_dat_w[g*DAT_WIDTH +: DAT_WIDTH];
        end else begin : g_pad
            assign vld8[g]  = 1'b0;
            assign we8[g]   = 1'b0;
            assign adr_a[g] = '0;
            assign dat_a[g] = '0;
        end
    end

    assign gnt_vld = vld8[gnt_idx];
    // The timeout cycle is decided from the counter alone so t_ready never reaches t_valid
    assign timeout = (state == BUSY) && gnt_vld && (cnt == CNT_W'(TIMEOUT - 1));
    assign done    = (state == BUSY) && gnt_vld && !timeout && t_ready;
    assign rr_adv  = (gnt_idx == IDX_W'(N_INIT - 1)) ? '0 : gnt_idx + 3'd1;

    // Lowest requester at or above rr_ptr wins, otherwise lowest requester overall
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        pick_any = 1'b0;
        for (int k = int'(MAX_INIT) - 1; k >= 0; k--) begin
            if (vld8[3'(k)]) begin
                pick_any = 1'b1;
                lo_idx   = 3'(k);
                if (3'(k) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(k);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_any) state_nxt = BUSY;
            BUSY: if (!gnt_vld || timeout || done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            cnt     <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (pick_any) gnt_idx <= pick_idx;
        end else if (timeout || done) begin
            cnt    <= '0;
            rr_ptr <= rr_adv;
        end else if (!gnt_vld) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        busy    = (state == BUSY);
        t_valid = 1'b0;
        t_adr   = '0;
        t_dat_w = '0;
        t_we    = 1'b0;
        rdy8    = '0;
        i_dat_r = t_dat_r;
        err     = 1'b0;
        if (state == BUSY) begin
            t_valid       = gnt_vld && !timeout;
            t_adr         = adr_a[gnt_idx];
            t_dat_w       = dat_a[gnt_idx];
            t_we          = we8[gnt_idx];
            rdy8[gnt_idx] = timeout || t_ready;
            if (timeout) begin
                i_dat_r = '1;
                err     = 1'b1;
            end
        end
    end

    assign i_ready = rdy8[N_INIT-1:0];

endmodule

// File: tb/tb_fwpic_reg_arb.sv
// Bench for fwpic_reg_arb: directed scenario tasks plus a randomized run checked
// against a transaction-level round-robin model.
module tb_fwpic_reg_arb;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*AW-1:0] i_adr;
    logic [N*DW-1:0] i_dat_w;
    logic [N-1:0]    i_we;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_ready;
    logic [DW-1:0]   i_dat_r;
    logic [AW-1:0]   t_adr;
    logic [DW-1:0]   t_dat_w;
    logic            t_we;
    logic            t_valid;
    logic            t_ready;
    logic [DW-1:0]   t_dat_r;
    logic [2:0]      gnt_idx;
    logic            busy;
    logic            err;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fwpic_reg_arb #(.N_INIT(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_we(i_we), .i_valid(i_valid),
        .i_ready(i_ready), .i_dat_r(i_dat_r),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_we(t_we), .t_valid(t_valid),
        .t_ready(t_ready), .t_dat_r(t_dat_r),
        .gnt_idx(gnt_idx), .busy(busy), .err(err)
    );

    // Reference model: who holds the port, whose turn is next, how long the grant has waited
    bit            m_busy;
    int            m_gnt;
    int            m_rr;
    int            m_wait;
    logic          e_tvalid, e_err, e_to, e_we;
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_datr, e_datw;
    logic [AW-1:0] e_adr;

    function automatic int first_from(int start, logic [N-1:0] v);
        for (int o = 0; o < int'(N); o++)
            if (v[(start + o) % int'(N)]) return (start + o) % int'(N);
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_gnt = 0; m_rr = 0; m_wait = 0;
    endtask

    task automatic model_eval();
        e_to = 1'b0; e_tvalid = 1'b0; e_rdy = '0; e_err = 1'b0;
        e_datr = t_dat_r; e_adr = '0; e_datw = '0; e_we = 1'b0;
        if (m_busy) begin
            e_to     = i_valid[m_gnt] && (m_wait == int'(TO));
            e_tvalid = i_valid[m_gnt] && !e_to;
            e_rdy[m_gnt] = e_to || t_ready;
            if (e_to) begin
                e_datr = '1;
                e_err  = 1'b1;
            end
            e_adr  = i_adr[m_gnt*int'(AW) +: AW];
            e_datw = i_dat_w[m_gnt*int'(DW) +: DW];
            e_we   = i_we[m_gnt];
        end
    endtask

    task automatic model_clock();
        int f;
        if (!reset) begin
            model_reset();
        end else if (!m_busy) begin
            f = first_from(m_rr, i_valid);
            if (f >= 0) begin
                m_busy = 1'b1; m_gnt = f; m_wait = 1;
            end
        end else if (!i_valid[m_gnt]) begin
            m_busy = 1'b0;
        end else if (e_to || t_ready) begin
            m_busy = 1'b0;
            m_rr   = (m_gnt + 1) % int'(N);
        end else begin
            m_wait++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; i_valid = '0; i_we = '0; i_adr = '0; i_dat_w = '0;
        t_ready = 1'b0; t_dat_r = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_valid = '1; t_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({busy, t_valid, i_ready, err, gnt_idx} !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b t_valid=%b i_ready=%b err=%b gnt=%0d want all 0",
                     busy, t_valid, i_ready, err, gnt_idx);
        end
        reset = 1'b1; i_valid = '0;
        tick();
    endtask

    task automatic test_single_write();
        apply_reset();
        i_adr[3:0] = 4'h2; i_dat_w[31:0] = 32'h0000_00FF; i_we = 3'b001;
        i_valid = 3'b001; t_ready = 1'b1;
        #1;
        checks++;
        if ({t_valid, i_ready} !== 4'b0) begin
            failures++;
            $display("FAIL write_idle got t_valid=%b i_ready=%b want 0", t_valid, i_ready);
        end
        tick();
        #1;
        checks++;
        if ({busy, t_valid, t_adr, t_dat_w, t_we, i_ready} !== {1'b1, 1'b1, 4'h2, 32'h0000_00FF, 1'b1, 3'b001}) begin
            failures++;
            $display("FAIL write_xfer got busy=%b t_valid=%b adr=%h dat=%h we=%b rdy=%b want 1 1 2 000000ff 1 001",
                     busy, t_valid, t_adr, t_dat_w, t_we, i_ready);
        end
        tick();
        i_valid = '0;
        #1;
        checks++;
        if ({busy, t_valid} !== 2'b00) begin
            failures++;
            $display("FAIL write_done got busy=%b t_valid=%b want 0 0", busy, t_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        i_valid = 3'b011; t_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            #1;
            checks++;
            if (c % 2 == 1) begin
                if ({busy, gnt_idx, i_ready} !== {1'b1, 3'((c - 1) / 2 % 2), 3'(1 << ((c - 1) / 2 % 2))}) begin
                    failures++;
                    $display("FAIL contention_c%0d got busy=%b gnt=%0d rdy=%b want busy=1 gnt=%0d",
                             c, busy, gnt_idx, i_ready, (c - 1) / 2 % 2);
                end
            end else if ({busy, i_ready} !== 4'b0) begin
                failures++;
                $display("FAIL contention_gap_c%0d got busy=%b rdy=%b want 0", c, busy, i_ready);
            end
        end
        i_valid = '0;
        tick();
    endtask

    task automatic test_read();
        apply_reset();
        i_valid = 3'b010; i_we = 3'b000; i_adr[7:4] = 4'h0; i_adr[3:0] = 4'h9;
        t_ready = 1'b1; t_dat_r = 32'h0000_0005;
        tick();
        #1;
        checks++;
        if ({busy, gnt_idx, i_ready, i_dat_r, t_we, t_adr} !== {1'b1, 3'd1, 3'b010, 32'h0000_0005, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL read got busy=%b gnt=%0d rdy=%b dat_r=%h we=%b adr=%h want 1 1 010 00000005 0 0",
                     busy, gnt_idx, i_ready, i_dat_r, t_we, t_adr);
        end
        tick();
        i_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        i_valid = 3'b011; t_ready = 1'b0; t_dat_r = 32'h1234_5678;
        tick();
        for (int b = 1; b <= int'(TO); b++) begin
            #1;
            checks++;
            if (b < int'(TO)) begin
                if ({err, t_valid, i_ready} !== {1'b0, 1'b1, 3'b000}) begin
                    failures++;
                    $display("FAIL timeout_wait_b%0d got err=%b t_valid=%b rdy=%b want 0 1 000",
                             b, err, t_valid, i_ready);
                end
            end else if ({err, t_valid, i_ready, i_dat_r} !== {1'b1, 1'b0, 3'b001, 32'hFFFF_FFFF}) begin
                failures++;
                $display("FAIL timeout_fire got err=%b t_valid=%b rdy=%b dat_r=%h want 1 0 001 ffffffff",
                         err, t_valid, i_ready, i_dat_r);
            end
            tick();
        end
        #1;
        checks++;
        if ({busy, err} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_idle got busy=%b err=%b want 0 0", busy, err);
        end
        tick();
        #1;
        checks++;
        if ({busy, gnt_idx} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL timeout_next got busy=%b gnt=%0d want 1 1", busy, gnt_idx);
        end
        i_valid = '0;
        tick();
    endtask

    task automatic test_withdraw();
        apply_reset();
        i_valid = 3'b011; t_ready = 1'b0;
        tick();
        i_valid = 3'b010;
        #1;
        checks++;
        if ({busy, gnt_idx, t_valid, err} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL withdraw_drop got busy=%b gnt=%0d t_valid=%b err=%b want 1 0 0 0",
                     busy, gnt_idx, t_valid, err);
        end
        tick();
        i_valid = 3'b011;
        #1;
        checks++;
        if ({busy, err} !== 2'b00) begin
            failures++;
            $display("FAIL withdraw_idle got busy=%b err=%b want 0 0", busy, err);
        end
        tick();
        #1;
        checks++;
        if ({busy, gnt_idx} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL withdraw_prio got busy=%b gnt=%0d want 1 0", busy, gnt_idx);
        end
        i_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_valid = 3'b100; t_ready = 1'b0; i_adr = 12'hA00;
        tick();
        #1;
        checks++;
        if ({busy, gnt_idx} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL rstmid_grant got busy=%b gnt=%0d want 1 2", busy, gnt_idx);
        end
        reset = 1'b0;
        tick();
        #1;
        checks++;
        if ({busy, t_valid, i_ready, err, gnt_idx, t_adr} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear got busy=%b t_valid=%b rdy=%b err=%b gnt=%0d adr=%h want all 0",
                     busy, t_valid, i_ready, err, gnt_idx, t_adr);
        end
        reset = 1'b1; i_valid = 3'b101;
        tick();
        #1;
        checks++;
        if ({busy, gnt_idx} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL rstmid_first got busy=%b gnt=%0d want 1 0", busy, gnt_idx);
        end
        i_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        logic [N-1:0] prev_rdy;
        int           stall;
        apply_reset();
        model_reset();
        req = '0; prev_rdy = '0; stall = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(199) != 0);
            if (stall > 0) begin
                t_ready = 1'b0;
                stall--;
            end else if ($urandom_range(49) == 0) begin
                stall   = 20;
                t_ready = 1'b0;
            end else begin
                t_ready = ($urandom_range(2) != 0);
            end
            for (int k = 0; k < int'(N); k++) begin
                if (req[k] && prev_rdy[k])   req[k] = ($urandom_range(1) == 0);
                else if (!req[k])            req[k] = ($urandom_range(2) == 0);
                else if ($urandom_range(39) == 0) req[k] = 1'b0;
                i_dat_w[k*int'(DW) +: DW] = $urandom;
            end
            i_valid = req;
            i_adr   = (N*AW)'($urandom);
            i_we    = N'($urandom);
            t_dat_r = $urandom;
            #1;
            model_eval();
            checks++;
            if ({t_valid, i_ready, err, busy, gnt_idx} !== {e_tvalid, e_rdy, e_err, m_busy, 3'(m_gnt)}) begin
                failures++;
                $display("FAIL rand_ctrl_c%0d got tv=%b rdy=%b err=%b busy=%b gnt=%0d want tv=%b rdy=%b err=%b busy=%b gnt=%0d",
                         c, t_valid, i_ready, err, busy, gnt_idx, e_tvalid, e_rdy, e_err, m_busy, m_gnt);
            end
            checks++;
            if (i_dat_r !== e_datr) begin
                failures++;
                $display("FAIL rand_datr_c%0d got %h want %h", c, i_dat_r, e_datr);
            end
            if (m_busy) begin
                checks++;
                if ({t_adr, t_dat_w, t_we} !== {e_adr, e_datw, e_we}) begin
                    failures++;
                    $display("FAIL rand_path_c%0d got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                             c, t_adr, t_dat_w, t_we, e_adr, e_datw, e_we);
                end
            end
            prev_rdy = e_rdy;
            model_clock();
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; i_valid = '0; i_we = '0; i_adr = '0; i_dat_w = '0;
        t_ready = 1'b0; t_dat_r = '0;
        tick();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
